mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-outstanding backing memory.
// Data requests have priority; a streak counter forces a fetch after MAX_DSTREAK data grants.
module mem_arbiter #(
  parameter int TIMEOUT     = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_if_req,
  input  logic [31:0] in_if_addr,
  output logic        out_if_ready,
  output logic [31:0] out_if_data,
  input  logic        in_d_req,
  input  logic        in_d_write,
  input  logic [31:0] in_d_addr,
  input  logic [31:0] in_d_data,
  output logic        out_d_ready,
  output logic [31:0] out_d_data,
  output logic        out_mem_req,
  output logic        out_mem_write,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_data,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_data,
  output logic        out_busy,
  output logic        out_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] STREAK_C  = 4'(MAX_DSTREAK);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t      state, next_state;
  logic [7:0]  cycle_cnt;
  logic [3:0]  streak;
  logic        grant_i, grant_d;
  logic        mem_done, mem_timeout, stray;
  logic [31:0] resp_word;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    mem_done    = 1'b0;
    mem_timeout = 1'b0;
    stray       = 1'b0;
    case (state)
      IDLE: begin
        stray = in_mem_valid;
        if (in_d_req && !(in_if_req && streak == STREAK_C)) begin
          grant_d    = 1'b1;
          next_state = WAIT_D;
        end else if (in_if_req) begin
          grant_i    = 1'b1;
          next_state = WAIT_I;
        end
      end
      WAIT_I, WAIT_D: begin
        // A completion in the issue cycle itself cannot be a real response.
        if (in_mem_valid && out_mem_req) begin
          stray = 1'b1;
        end else if (in_mem_valid) begin
          mem_done = 1'b1;
        end else if (cycle_cnt == TIMEOUT_C) begin
          mem_timeout = 1'b1;
        end
        if (mem_done || mem_timeout) begin
          next_state = (state == WAIT_I) ? RESP_I : RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        stray      = in_mem_valid;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign resp_word = mem_done ? in_mem_data : 32'h0000_0000;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      streak        <= '0;
      out_if_ready  <= 1'b0;
      out_if_data   <= '0;
      out_d_ready   <= 1'b0;
      out_d_data    <= '0;
      out_mem_req   <= 1'b0;
      out_mem_write <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_data  <= '0;
      out_busy      <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      state        <= next_state;
      out_if_ready <= (next_state == RESP_I);
      out_d_ready  <= (next_state == RESP_D);
      out_busy     <= (next_state != IDLE);
      out_mem_req  <= grant_i || grant_d;

      if (stray || mem_timeout) begin
        out_err <= 1'b1;
      end

      if (grant_d) begin
        out_mem_addr  <= in_d_addr;
        out_mem_data  <= in_d_data;
        out_mem_write <= in_d_write;
        if (!in_if_req) begin
          streak <= '0;
        end else if (streak != STREAK_C) begin
          streak <= streak + 4'd1;
        end
      end else if (grant_i) begin
        out_mem_addr  <= in_if_addr;
        out_mem_data  <= '0;
        out_mem_write <= 1'b0;
        streak        <= '0;
      end

      if (grant_i || grant_d) begin
        cycle_cnt <= 8'd1;
      end else if (next_state == WAIT_I || next_state == WAIT_D) begin
        cycle_cnt <= cycle_cnt + 8'd1;
      end else begin
        cycle_cnt <= '0;
      end

      if (mem_done || mem_timeout) begin
        if (state == WAIT_I) begin
          out_if_data <= resp_word;
        end else if (!out_mem_write) begin
          out_d_data <= resp_word;
        end
      end
    end
  end

endmodule
